// File: rtl/prog_loader.sv
// prog_loader: loads the 16 x 8-bit program memory from a byte stream and gates CPU run on a good checksum
module prog_loader #(
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              int_osc,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_err
);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   csum_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                in_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_run_q;
    logic                busy_q;
    logic                load_err_q;

    logic                xfer;
    logic                is_sync;
    logic                tmo_hit;
    logic [DATA_W-1:0]   csum_d;

    assign xfer     = in_valid & in_ready_q;
    assign is_sync  = in_data == SYNC_BYTE;
    assign tmo_hit  = tmo_q == TMO_W'(TIMEOUT - 1);
    assign csum_d   = csum_q + in_data;

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign busy      = busy_q;
    assign load_err  = load_err_q;

    // Loader FSM; every output is registered alongside the state transition that implies it
    always_ff @(posedge int_osc) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    tmo_q <= '0;
                    if (xfer && is_sync) begin
                        state_q    <= S_LOAD;
                        addr_q     <= '0;
                        csum_q     <= '0;
                        cpu_run_q  <= 1'b0;
                        load_err_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        state_q     <= S_WRITE;
                        csum_q      <= csum_d;
                        tmo_q       <= '0;
                        in_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= in_data;
                    end else if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        tmo_q      <= '0;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    in_ready_q <= 1'b1;
                    tmo_q      <= '0;
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_CHECK;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        tmo_q  <= '0;
                        busy_q <= 1'b0;
                        if (csum_d == '0) begin
                            state_q   <= S_DONE;
                            cpu_run_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERROR;
                            load_err_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        tmo_q      <= '0;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    cpu_run_q  <= 1'b0;
                    tmo_q      <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: vector table plus scoreboarded image loads for prog_loader
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, mem_we, cpu_run, busy, load_err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         wcount = 0;
    int         cyc = 0;
    logic [3:0] tb_addr = '0;
    logic [11:0] sbq[$];

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       push;
        logic [4:0] exp;
    } vec_t;

    prog_loader dut (
        .int_osc(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Scoreboard: every write strobe must match the oldest pushed {addr,data}
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wcount++;
            if (sbq.size() == 0) check("unexpected_write", {20'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check("mem_write", {20'd0, mem_addr, mem_wdata}, {20'd0, sbq.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic sync(input bit keep);
        send_byte(8'hA5, keep);
        tb_addr = '0;
    endtask

    task automatic load_byte(input logic [7:0] b, input bit keep);
        sbq.push_back({tb_addr, b});
        tb_addr = tb_addr + 1'b1;
        send_byte(b, keep);
    endtask

    function automatic logic [7:0] img(input int i);
        return i[0] ? 8'h20 : 8'h10;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs", {15'd0, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, load_err},
              {15'd0, 1'b1, 1'b0, 4'h0, 8'h00, 3'b000});
        rst = 1'b0;
        sbq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   w0, prev, bad;
        vecs = '{
            '{1'b1, 8'h00, 1'b0, 5'b10000},
            '{1'b1, 8'hFF, 1'b0, 5'b10000},
            '{1'b1, 8'h12, 1'b0, 5'b10000},
            '{1'b0, 8'hA5, 1'b0, 5'b10000},
            '{1'b1, 8'hA5, 1'b0, 5'b10010},
            '{1'b1, 8'hA5, 1'b1, 5'b01010},
            '{1'b1, 8'h77, 1'b0, 5'b10010},
            '{1'b0, 8'h77, 1'b0, 5'b10010},
            '{1'b1, 8'h3C, 1'b1, 5'b01010}
        };
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Per-cycle vectors: junk in IDLE, SYNC, data bytes; exp = {ready,we,run,busy,err}
        tb_addr = '0;
        for (int i = 0; i < 9; i++) begin
            in_valid = vecs[i].vld;
            in_data  = vecs[i].dat;
            if (vecs[i].push) begin
                sbq.push_back({tb_addr, vecs[i].dat});
                tb_addr = tb_addr + 1'b1;
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {27'd0, in_ready, mem_we, cpu_run, busy, load_err},
                  {27'd0, vecs[i].exp});
            if (i == 3) check("idle_junk_no_write", wcount, 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("vec_writes", wcount, 2);
        do_reset();

        // Good image
        w0 = wcount;
        sync(0);
        for (int i = 0; i < 16; i++) load_byte(img(i), 0);
        check("pre_csum_run_busy", {30'd0, cpu_run, busy}, 32'b01);
        send_byte(8'h80, 0);
        @(posedge clk); #1;
        check("good_run_busy_err", {29'd0, cpu_run, busy, load_err}, 32'b100);
        check("good_writes", wcount - w0, 16);
        check("good_sb_empty", sbq.size(), 0);
        sync(0);
        check("done_resync_run_busy", {30'd0, cpu_run, busy}, 32'b01);
        do_reset();

        // Bad checksum
        w0 = wcount;
        sync(0);
        for (int i = 0; i < 16; i++) load_byte(img(i), 0);
        send_byte(8'h81, 0);
        check("bad_run_busy_err_rdy", {28'd0, cpu_run, busy, load_err, in_ready}, 32'b0011);
        check("bad_writes", wcount - w0, 16);
        send_byte(8'h10, 0);
        check("err_sticky", {30'd0, cpu_run, load_err}, 32'b01);
        sync(0);
        check("err_cleared_by_sync", {30'd0, busy, load_err}, 32'b10);
        do_reset();

        // Timeout after byte 5
        w0 = wcount;
        sync(0);
        for (int i = 0; i < 5; i++) load_byte(img(i), 0);
        repeat (1024) @(posedge clk);
        #1;
        check("tmo_not_yet", 32'(load_err), 32'd0);
        @(posedge clk); #1;
        check("tmo_err_busy", {30'd0, load_err, busy}, 32'b10);
        check("tmo_writes", wcount - w0, 5);

        // Transfer on the exact expiry cycle wins
        w0 = wcount;
        sync(0);
        for (int i = 0; i < 5; i++) load_byte(img(i), 0);
        repeat (1024) @(posedge clk);
        #1;
        for (int i = 5; i < 16; i++) load_byte(img(i), 0);
        check("expiry_win_no_err", 32'(load_err), 32'd0);
        send_byte(8'h80, 0);
        check("expiry_win_done", {30'd0, cpu_run, load_err}, 32'b10);
        check("expiry_win_writes", wcount - w0, 16);
        do_reset();

        // Continuous in_valid: one accepted byte every two cycles
        w0 = wcount;
        bad = 0;
        sync(1);
        prev = cyc;
        for (int i = 0; i < 16; i++) begin
            load_byte(img(i), 1);
            if (i > 0 && cyc - prev != 2) bad++;
            if (in_ready !== 1'b0) bad++;
            prev = cyc;
        end
        send_byte(8'h80, 0);
        check("throughput_pattern", bad, 0);
        check("throughput_writes", wcount - w0, 16);
        check("throughput_done", {30'd0, cpu_run, load_err}, 32'b10);
        do_reset();

        // Reset after byte 9, then full reload from address 0
        sync(0);
        for (int i = 0; i < 9; i++) load_byte(img(i), 0);
        do_reset();
        check("abandon_sb_empty", sbq.size(), 0);
        w0 = wcount;
        sync(0);
        for (int i = 0; i < 16; i++) load_byte(img(i), 0);
        send_byte(8'h80, 0);
        @(posedge clk); #1;
        check("reload_done", {29'd0, cpu_run, busy, load_err}, 32'b100);
        check("reload_writes", wcount - w0, 16);
        check("reload_sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
